// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the RISC local-bus arbiter.
// Imported by the arbiter top and its winner-select helper.
package risc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCAL,
        EXT
    } state_t;

    localparam logic [2:0] ENDIAN_RST = 3'b011;
    localparam int         REG_CTRL   = 0;

endpackage

// File: rtl/risc_mem_arb_rr_pick.sv
// Combinational winner select: ch0 absolute, then fixed or round-robin.
// Round-robin wraps within channels 1..NCH-1 starting at ptr.
module rr_pick
    import risc_mem_pkg::*;
#(
    parameter int NCH = 4,
    parameter int RR  = 0
) (
    input  logic [NCH-1:0] req,
    input  logic [2:0]     ptr,
    output logic           any,
    output logic [2:0]     win
);

    logic hit;

    always_comb begin
        any = |req;
        win = 3'd0;
        hit = 1'b0;
        if (!req[0]) begin
            if (RR == 0) begin
                for (int j = NCH - 1; j >= 1; j--) begin
                    if (req[j]) win = 3'(j);
                end
            end else begin
                // descending scans leave the lowest matching index in win
                for (int j = NCH - 1; j >= 1; j--) begin
                    if (req[j] && j >= int'(ptr)) begin
                        win = 3'(j);
                        hit = 1'b1;
                    end
                end
                if (!hit) begin
                    for (int j = NCH - 1; j >= 1; j--) begin
                        if (req[j]) win = 3'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/risc_mem_arb.sv
// N-channel local-bus arbiter and register decoder for the GPU/DSP cores.
// Grants one requester at a time to local RAM/registers or an external cycle.
module risc_mem_arb
    import risc_mem_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             AW       = 24,
    parameter int             DW       = 32,
    parameter int             RR       = 0,
    parameter logic [AW-1:0]  LOCAL_LO = 24'hF02000,
    parameter logic [AW-1:0]  LOCAL_HI = 24'hF07FFF,
    parameter logic [AW-1:0]  REG_BASE = 24'hF02100,
    parameter int             NREG     = 8
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic              ce,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH-1:0]    abort,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    ack,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    output logic              bus_we,
    output logic              local_sel,
    output logic              ext_req,
    input  logic              ext_ack,
    output logic [NREG-1:0]   reg_wr,
    output logic [NREG-1:0]   reg_rd,
    input  logic              lock_set,
    output logic              lock,
    output logic [2:0]        endian,
    output logic              busy
);

    state_t          state, state_nx;
    logic [2:0]      g, g_nx, ptr, ptr_nx, win;
    logic            any, load, gw, ab_g, wr_ok;
    logic [AW-1:0]   ga;
    logic [DW-1:0]   gd;
    logic [NCH-1:0]  gh, ack_nx;
    logic [NREG-1:0] hit, wr_nx, rd_nx;
    logic [AW-3:0]   ri;
    logic [2:0]      endian_nx;
    logic            lock_nx, local_nx, ext_nx;

    rr_pick #(
        .NCH (NCH),
        .RR  (RR)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    always_comb begin
        ga = '0;
        gd = '0;
        gw = 1'b0;
        gh = '0;
        for (int c = 0; c < NCH; c++) begin
            if (win == 3'(c)) begin
                ga = addr[c*AW +: AW];
                gd = wdata[c*DW +: DW];
                gw = we[c];
            end
            gh[c] = (g == 3'(c));
        end
        ab_g = |(abort & gh);
    end

    // below-base addresses wrap to large offsets and match nothing
    assign ri = bus_addr[AW-1:2] - REG_BASE[AW-1:2];

    always_comb begin
        hit = '0;
        for (int i = 0; i < NREG; i++) begin
            hit[i] = (ri == (AW-2)'(i));
        end
    end

    assign wr_ok = bus_we &
                   ~(lock & (g == 3'd0) & ~hit[REG_CTRL]);
    assign busy  = (state != IDLE);

    always_comb begin
        state_nx  = state;
        g_nx      = g;
        ptr_nx    = ptr;
        load      = 1'b0;
        ack_nx    = '0;
        wr_nx     = '0;
        rd_nx     = '0;
        local_nx  = 1'b0;
        ext_nx    = 1'b0;
        endian_nx = endian;
        lock_nx   = lock;
        unique case (state)
            IDLE: begin
                if (any) begin
                    load = 1'b1;
                    g_nx = win;
                    if ((ga >= LOCAL_LO && ga <= LOCAL_HI) || win == 3'd0) begin
                        state_nx = LOCAL;
                        local_nx = 1'b1;
                    end else begin
                        state_nx = EXT;
                        ext_nx   = 1'b1;
                    end
                end
            end
            LOCAL: begin
                ack_nx   = gh;
                wr_nx    = wr_ok ? hit : '0;
                rd_nx    = bus_we ? '0 : hit;
                state_nx = IDLE;
                if (bus_we && hit[REG_CTRL]) begin
                    endian_nx = bus_wdata[2:0];
                    lock_nx   = 1'b0;
                end
                if (RR != 0 && g != 3'd0) begin
                    ptr_nx = (g == 3'(NCH - 1)) ? 3'd1 : g + 3'd1;
                end
            end
            EXT: begin
                if (ext_ack) begin
                    ack_nx   = gh;
                    state_nx = IDLE;
                end else if (ab_g) begin
                    state_nx = IDLE;
                end else begin
                    ext_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (lock_set) lock_nx = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state     <= IDLE;
            g         <= 3'd0;
            ptr       <= 3'd1;
            ack       <= '0;
            reg_wr    <= '0;
            reg_rd    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            local_sel <= 1'b0;
            ext_req   <= 1'b0;
            endian    <= ENDIAN_RST;
            lock      <= 1'b0;
        end else if (ce) begin
            state     <= state_nx;
            g         <= g_nx;
            ptr       <= ptr_nx;
            ack       <= ack_nx;
            reg_wr    <= wr_nx;
            reg_rd    <= rd_nx;
            local_sel <= local_nx;
            ext_req   <= ext_nx;
            endian    <= endian_nx;
            lock      <= lock_nx;
            if (load) begin
                bus_addr  <= ga;
                bus_wdata <= gd;
                bus_we    <= gw;
            end
        end
    end

endmodule

// File: doc/risc_mem_arb.md
Name: risc_mem_arb

Overview:
- N-channel local-bus arbiter and register decoder for the RISC cores: GPU and DSP instances, selected by parameter.
- Arbitrates requesters (ch0 = CPU I/O, highest priority; others = gate/data/prefetch) onto one shared bus.
- Routes each granted cycle to local RAM/registers or to an external handshake, and holds the endian and lock control state.
- Successor to the fixed four-requester GPU/DSP memory controller. Adds parametrised channel count and address map, optional round-robin, a multi-cycle external wait with per-channel abort, and one-hot register strobes.

Parameters:
- NCH, 4, number of requesters (2..8); ch0 is always highest priority.
- AW, 24, address width.
- DW, 32, data width.
- RR, 0, 0 = fixed priority (lower index wins); 1 = round-robin among ch1..NCH-1, ch0 still absolute.
- LOCAL_LO, 24'hF02000, inclusive low bound of local window.
- LOCAL_HI, 24'hF07FFF, inclusive high bound of local window.
- REG_BASE, 24'hF02100, base of register block (long-aligned).
- NREG, 8, number of long registers decoded.

Ports:
- sys_clk  in  1  system clock.
- resetl  in  1  synchronous active-low reset.
- ce  in  1  bus-cycle enable; all state advances only when ce=1.
- req  in  NCH  per-channel request, level held until ack.
- we  in  NCH  per-channel write flag.
- abort  in  NCH  per-channel abort of a pending external cycle.
- addr  in  NCH*AW  flattened addresses; channel c occupies [c*AW +: AW].
- wdata  in  NCH*DW  flattened write data, same layout as addr.
- ack  out  NCH  one-hot acknowledge, one ce-cycle wide.
- bus_addr  out  AW  granted address, registered.
- bus_wdata  out  DW  granted write data, registered.
- bus_we  out  1  registered write strobe.
- local_sel  out  1  current cycle targets the local window.
- ext_req  out  1  external cycle pending.
- ext_ack  in  1  external completion.
- reg_wr  out  NREG  one-hot register write strobes.
- reg_rd  out  NREG  one-hot register read strobes.
- lock_set  in  1  sets lock at next ce.
- lock  out  1  lock state.
- endian  out  3  {big_instr, big_pix, big_io}.
- busy  out  1  bus not IDLE.

Behaviour:
Reset (resetl=0 at a sys_clk edge, independent of ce):
- state=IDLE; ack, reg_wr, reg_rd, bus_we, ext_req, local_sel = 0.
- bus_addr, bus_wdata = 0.
- endian=3'b011; lock=0; round-robin pointer = 1.

FSM, evaluated on sys_clk when ce=1:
- IDLE: if any req, grant the winner g. Winner is ch0 if req[0]; else the lowest-index request (RR=0), or the first request at or after the pointer, wrapping within 1..NCH-1 (RR=1).
  - Latch addr[g], wdata[g], we[g] into the bus registers.
  - If the address is in [LOCAL_LO, LOCAL_HI] or g=0: go to LOCAL, local_sel=1.
  - Otherwise go to EXT, ext_req=1.
- LOCAL: ack[g]=1 for this cycle only. reg_wr/reg_rd decode fires this cycle. Return to IDLE. With RR=1, the pointer advances to g+1 (wrapping 1..NCH-1) if g≠0.
- EXT: hold ext_req=1 until ext_ack or abort[g].
  - ext_ack: ack[g]=1, ext_req=0, go to IDLE.
  - abort[g] with no ext_ack: go to IDLE with no ack.
  - ext_ack and abort[g] together: ack wins.
  - ch0 requests during EXT wait; there is no pre-emption.
- Arbitration latency: 1 ce-cycle request-to-service; local ack 2 ce-cycles after req rises.
- ce=0: all registers hold, ack pulses stretch, ext_ack is ignored.

Register decode (LOCAL only):
- Offset index i = bus_addr[AW-1:2] - REG_BASE[AW-1:2], valid when 0 ≤ i < NREG.
- reg_wr[i] = bus_we; reg_rd[i] = ~bus_we.
- Write to index 0 sets endian = bus_wdata[2:0] and clears lock.
- While lock=1, writes from ch0 to index ≠0 are suppressed: no reg_wr strobe, ack still given. Reads are unaffected.
- lock_set and a clearing write to index 0 in the same cycle: lock_set wins.

Mid-operation reset: resetl=0 during EXT drops ext_req with no ack.

Decomposition:
- Package risc_mem_pkg: state enum {IDLE, LOCAL, EXT}; endian reset constant 3'b011; register index constants (REG_CTRL=0).
- One sub-module, rr_pick: combinational winner-select (fixed/round-robin) over a request vector and pointer.

Test Plan:
- Reset release: req=0 -> busy=0, endian=3'b011, lock=0, ack=0.
- req=4'b0110 (both ch1 and ch2 at local 24'hF03000), RR=0 -> ch1 acked first, ch2 acked 2 ce-cycles later. RR=1 with pointer=2 -> ch2 first.
- ch1 read at 24'hF18000 -> ext_req=1 stays high for 5 cycles, ext_ack pulse -> ack[1]=1 same cycle, ext_req=0. A repeat run raising abort[1] on cycle 3 -> IDLE, no ack.
- ch0 write at 24'hF02100, data 32'h5 -> reg_wr=8'b0000_0001, endian=3'b101.
- lock_set, then ch0 write at 24'hF02104 -> ack[0]=1, reg_wr=0. Then ch0 write at 24'hF02100 -> lock=0.
- ce held low for 3 cycles mid-LOCAL -> ack held constant; resetl=0 during EXT -> ext_req=0 next edge, no ack.
